pipe_rx_detect_ctrl: RTL and testbench

Parametrised PIPE receiver-detect sequencer for the LTSSM Detect.Active substate. Generalises the fixed 16-lane detect logic embedded in the TX top to any lane count. Adds per-lane detect masks, PhyStatus timeout, bounded retry and contiguous link-width derivation. The main LTSSM starts it; its results feed numberOfDetectedLanesIn / writeNumberOfDetectedLanes.

---
 rtl/pipe_detect_pkg.sv | 37 +++
 rtl/lane_width_calc.sv | 54 +++++
 rtl/pipe_rx_detect_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pipe_rx_detect_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_detect_pkg.sv
// rtl/pipe_detect_pkg.sv - shared types and constants for the PIPE receiver-detect sequencer
//
// Holds the detect FSM state encoding, the RxStatus code that signals a
// detected receiver, PIPE PowerDown codes and the link-width encodings
// used by lane_width_calc and pipe_rx_detect_ctrl.
package pipe_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DETECT_REQ,
    DETECT_WAIT,
    EVAL,
    RETRY_WAIT,
    DONE
  } det_state_e;

  localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;

  localparam logic [3:0] POWERDOWN_P0  = 4'd0;
  localparam logic [3:0] POWERDOWN_P0S = 4'd1;
  localparam logic [3:0] POWERDOWN_P1  = 4'd2;
  localparam logic [3:0] POWERDOWN_P2  = 4'd3;

  localparam logic [5:0] WIDTH_X0  = 6'd0;
  localparam logic [5:0] WIDTH_X1  = 6'd1;
  localparam logic [5:0] WIDTH_X2  = 6'd2;
  localparam logic [5:0] WIDTH_X4  = 6'd4;
  localparam logic [5:0] WIDTH_X8  = 6'd8;
  localparam logic [5:0] WIDTH_X16 = 6'd16;
  localparam logic [5:0] WIDTH_X32 = 6'd32;

  // Candidate link widths in increasing order; the last one that fits wins.
  localparam int NUM_WIDTHS = 6;
  localparam logic [5:0] WIDTH_CODES [NUM_WIDTHS] =
    '{WIDTH_X1, WIDTH_X2, WIDTH_X4, WIDTH_X8, WIDTH_X16, WIDTH_X32};

endpackage

// File: rtl/lane_width_calc.sv
// rtl/lane_width_calc.sv - popcount and contiguous link width over a detected-lane mask
//
// Purely combinational; also used by the LTSSM when upconfiguring.
// Ports:
//   det_i        detected-lane mask
//   count_o      number of set bits in det_i
//   width_o      largest supported width w with det_i[w-1:0] all set (0 if lane 0 missing)
//   width_rev_o  same, counted from the top lane downward; 0 when REV_EN=0
module lane_width_calc
  import pipe_detect_pkg::*;
#(
  parameter int LANES  = 16,
  parameter bit REV_EN = 1'b0
) (
  input  logic [LANES-1:0]         det_i,
  output logic [$clog2(LANES+1)-1:0] count_o,
  output logic [5:0]               width_o,
  output logic [5:0]               width_rev_o
);

  localparam int CW = $clog2(LANES + 1);

  logic fwd_ok;
  logic rev_ok;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      count_o = count_o + CW'(det_i[i]);
    end
  end

  always_comb begin
    width_o     = WIDTH_X0;
    width_rev_o = WIDTH_X0;
    fwd_ok      = 1'b0;
    rev_ok      = 1'b0;
    for (int k = 0; k < NUM_WIDTHS; k++) begin
      if (int'(WIDTH_CODES[k]) <= LANES) begin
        fwd_ok = 1'b1;
        rev_ok = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          if (i < int'(WIDTH_CODES[k])) begin
            if (!det_i[i]) fwd_ok = 1'b0;
            if (!det_i[LANES-1-i]) rev_ok = 1'b0;
          end
        end
        if (fwd_ok) width_o = WIDTH_CODES[k];
        if (rev_ok && REV_EN) width_rev_o = WIDTH_CODES[k];
      end
    end
  end

endmodule

// File: rtl/pipe_rx_detect_ctrl.sv
// rtl/pipe_rx_detect_ctrl.sv - PIPE receiver-detect sequencer for LTSSM Detect.Active
//
// Issues TxDetectRx_Loopback to every lane, collects per-lane PhyStatus /
// RxStatus, retries a bounded number of times when nothing is found, and
// reports the detected mask, its popcount and the contiguous link width.
// Optional macro LANE_REVERSAL_EN adds lane_reversed and lets the width be
// taken from the top lane downward when that gives a wider link.
// Ports:
//   clk, reset            PCLK, asynchronous active-high reset
//   start, abort          sequence start pulse, synchronous abort
//   PhyStatus, RxStatus   per-lane PIPE status inputs
//   TxDetectRx_Loopback   per-lane detect request
//   PowerDown, TxElecIdle held at PD_P1 / electrical idle during detect
//   busy, done            sequence in progress, one-cycle results-valid pulse
//   detected_mask/count, link_width, timeout_err, [lane_reversed]  results
module pipe_rx_detect_ctrl
  import pipe_detect_pkg::*;
#(
  parameter int         LANES          = 16,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         RETRY_GAP      = 256,
  parameter int         MAX_ATTEMPTS   = 2,
  parameter logic [3:0] PD_P1          = POWERDOWN_P1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LANES-1:0]             PhyStatus,
  input  logic [3*LANES-1:0]           RxStatus,
  output logic [LANES-1:0]             TxDetectRx_Loopback,
  output logic [4*LANES-1:0]           PowerDown,
  output logic [LANES-1:0]             TxElecIdle,
  output logic                         busy,
  output logic                         done,
  output logic [LANES-1:0]             detected_mask,
  output logic [$clog2(LANES+1)-1:0]   detected_count,
  output logic [5:0]                   link_width,
`ifdef LANE_REVERSAL_EN
  output logic                         lane_reversed,
`endif
  output logic                         timeout_err
);

  localparam int CW = $clog2(LANES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
`ifdef LANE_REVERSAL_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  det_state_e        state_q, state_d;
  logic [AW-1:0]     attempt_q, attempt_d;
  logic [LANES-1:0]  resp_q, resp_d;
  logic [LANES-1:0]  det_q, det_d;
  logic              to_q, to_d;
  logic [TW-1:0]     wait_tmr_q, wait_tmr_d;
  logic [GW-1:0]     gap_tmr_q, gap_tmr_d;
  logic              res_load;

  logic [LANES-1:0]  mask_q;
  logic [CW-1:0]     count_q;
  logic [5:0]        width_q;
  logic              to_err_q;
`ifdef LANE_REVERSAL_EN
  logic              rev_q;
`endif

  logic [CW-1:0]     count_w;
  logic [5:0]        width_fwd_w;
  logic [5:0]        width_rev_w;
  logic              use_rev;

  lane_width_calc #(
    .LANES  (LANES),
    .REV_EN (REV_EN)
  ) u_width (
    .det_i       (det_q),
    .count_o     (count_w),
    .width_o     (width_fwd_w),
    .width_rev_o (width_rev_w)
  );

  // width_rev_w is forced to 0 when reversal is disabled, so this never picks it.
  assign use_rev = (width_rev_w > width_fwd_w);

  always_comb begin
    state_d    = state_q;
    attempt_d  = attempt_q;
    resp_d     = resp_q;
    det_d      = det_q;
    to_d       = to_q;
    wait_tmr_d = wait_tmr_q;
    gap_tmr_d  = gap_tmr_q;
    res_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DETECT_REQ;
          attempt_d = AW'(1);
          resp_d    = '0;
          det_d     = '0;
          to_d      = 1'b0;
        end
      end
      DETECT_REQ: begin
        wait_tmr_d = '0;
        state_d    = DETECT_WAIT;
      end
      DETECT_WAIT: begin
        // Only the first PhyStatus of a lane in an attempt is captured.
        for (int i = 0; i < LANES; i++) begin
          if (PhyStatus[i] && !resp_q[i]) begin
            resp_d[i] = 1'b1;
            det_d[i]  = (RxStatus[3*i +: 3] == RXSTATUS_DETECTED);
          end
        end
        if (&resp_d) begin
          state_d = EVAL;
        end else if (wait_tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = EVAL;
          to_d    = 1'b1;
        end else begin
          // Leaving at the terminal count keeps the timer from ever wrapping.
          wait_tmr_d = wait_tmr_q + 1'b1;
        end
      end
      EVAL: begin
        if ((det_q != '0) || (attempt_q == AW'(MAX_ATTEMPTS))) begin
          state_d  = DONE;
          res_load = 1'b1;
        end else begin
          state_d   = RETRY_WAIT;
          attempt_d = attempt_q + 1'b1;
          gap_tmr_d = '0;
        end
      end
      RETRY_WAIT: begin
        if (gap_tmr_q == GW'(RETRY_GAP - 1)) begin
          state_d = DETECT_REQ;
          resp_d  = '0;
          det_d   = '0;
          to_d    = 1'b0;
        end else begin
          gap_tmr_d = gap_tmr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over everything, including a coincident start.
    if (abort) begin
      state_d  = IDLE;
      res_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      attempt_q  <= '0;
      resp_q     <= '0;
      det_q      <= '0;
      to_q       <= 1'b0;
      wait_tmr_q <= '0;
      gap_tmr_q  <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      width_q    <= WIDTH_X0;
      to_err_q   <= 1'b0;
`ifdef LANE_REVERSAL_EN
      rev_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      attempt_q  <= attempt_d;
      resp_q     <= resp_d;
      det_q      <= det_d;
      to_q       <= to_d;
      wait_tmr_q <= wait_tmr_d;
      gap_tmr_q  <= gap_tmr_d;
      // Results are latched on the way into DONE so they are valid with done.
      if (res_load) begin
        mask_q   <= det_q;
        count_q  <= count_w;
        width_q  <= use_rev ? width_rev_w : width_fwd_w;
        to_err_q <= to_q;
`ifdef LANE_REVERSAL_EN
        rev_q    <= use_rev;
`endif
      end
    end
  end

  always_comb begin
    TxDetectRx_Loopback = '0;
    if (state_q == DETECT_REQ) begin
      TxDetectRx_Loopback = '1;
    end else if (state_q == DETECT_WAIT) begin
      TxDetectRx_Loopback = ~resp_q;
    end
  end

  assign PowerDown      = {LANES{PD_P1}};
  assign TxElecIdle     = '1;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign detected_mask  = mask_q;
  assign detected_count = count_q;
  assign link_width     = width_q;
  assign timeout_err    = to_err_q;
`ifdef LANE_REVERSAL_EN
  assign lane_reversed  = rev_q;
`endif

endmodule

// File: tb/tb_pipe_rx_detect_ctrl.sv
// tb/tb_pipe_rx_detect_ctrl.sv - self-checking bench for pipe_rx_detect_ctrl
module tb_pipe_rx_detect_ctrl;

  localparam int LANES          = 16;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int RETRY_GAP      = 256;
  localparam int MAX_ATTEMPTS   = 2;
  localparam int CW             = $clog2(LANES + 1);

  logic                 clk = 1'b0;
  logic                 reset, start, abort;
  logic [LANES-1:0]     PhyStatus;
  logic [3*LANES-1:0]   RxStatus;
  logic [LANES-1:0]     TxDetectRx_Loopback;
  logic [4*LANES-1:0]   PowerDown;
  logic [LANES-1:0]     TxElecIdle;
  logic                 busy, done;
  logic [LANES-1:0]     detected_mask;
  logic [CW-1:0]        detected_count;
  logic [5:0]           link_width;
  logic                 timeout_err;
`ifdef LANE_REVERSAL_EN
  logic                 lane_reversed;
`endif

  pipe_rx_detect_ctrl #(
    .LANES          (LANES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .RETRY_GAP      (RETRY_GAP),
    .MAX_ATTEMPTS   (MAX_ATTEMPTS),
    .PD_P1          (4'd2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .PhyStatus           (PhyStatus),
    .RxStatus            (RxStatus),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .PowerDown           (PowerDown),
    .TxElecIdle          (TxElecIdle),
    .busy                (busy),
    .done                (done),
    .detected_mask       (detected_mask),
    .detected_count      (detected_count),
    .link_width          (link_width),
`ifdef LANE_REVERSAL_EN
    .lane_reversed       (lane_reversed),
`endif
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          delay;
    logic [15:0] resp;
    logic [15:0] det1;
    logic [15:0] det2;
    bit          sticky;
    logic [15:0] e_mask;
    int          e_cnt;
    int          e_w;
    int          e_wlr;
    bit          e_rev;
    bit          e_to;
    int          e_cyc;
    int          e_att;
  } vec_t;

  typedef struct {
    logic [15:0] mask;
    int          cnt;
    int          w;
    bit          rev;
    bit          to;
    int          cyc;
    int          att;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] last_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [63:0] pd_exp;
    for (int i = 0; i < LANES; i++) pd_exp[4*i +: 4] = 4'd2;
    chk({tag, "_req"},   TxDetectRx_Loopback, 0);
    chk({tag, "_pd"},    PowerDown, pd_exp);
    chk({tag, "_eidle"}, TxElecIdle, 16'hFFFF);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_mask"},  detected_mask, 0);
    chk({tag, "_count"}, detected_count, 0);
    chk({tag, "_width"}, link_width, 0);
    chk({tag, "_to"},    timeout_err, 0);
`ifdef LANE_REVERSAL_EN
    chk({tag, "_rev"},   lane_reversed, 0);
`endif
  endtask

  // Drives one detect sequence through a small PHY model: each responding
  // lane answers `delay` cycles after its request is first seen.
  task automatic run_vec(input vec_t v);
    exp_t             e, g;
    int               rq[LANES];
    bit               got[LANES];
    logic [LANES-1:0] got_m;
    int               cyc, att, last_req, done_cnt;
    bit               prev_any, detbit;
    e.mask = v.e_mask;
    e.cnt  = v.e_cnt;
`ifdef LANE_REVERSAL_EN
    e.w    = v.e_wlr;
`else
    e.w    = v.e_w;
`endif
    e.rev  = v.e_rev;
    e.to   = v.e_to;
    e.cyc  = v.e_cyc;
    e.att  = v.e_att;
    sb.push_back(e);
    n_vec++;
    for (int i = 0; i < LANES; i++) begin
      rq[i]  = -1;
      got[i] = 1'b0;
    end
    att = 0; prev_any = 1'b0; last_req = 0; done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= e.cyc + 2) begin
      if ((|TxDetectRx_Loopback) && !prev_any) begin
        att++;
        if (att == 2) chk("retry_gap", cyc - last_req - 1, RETRY_GAP + 1);
        for (int i = 0; i < LANES; i++) begin
          rq[i]  = -1;
          got[i] = 1'b0;
        end
      end
      prev_any = |TxDetectRx_Loopback;
      if (prev_any) last_req = cyc;
      for (int i = 0; i < LANES; i++) got_m[i] = got[i];
      chk("req_drop", TxDetectRx_Loopback & got_m, 0);
      if (done) begin
        done_cnt++;
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk("mask",        detected_mask, g.mask);
          chk("count",       detected_count, g.cnt);
          chk("width",       link_width, g.w);
          chk("timeout_err", timeout_err, g.to);
          chk("done_cycle",  cyc, g.cyc);
          chk("attempts",    att, g.att);
`ifdef LANE_REVERSAL_EN
          chk("lane_reversed", lane_reversed, g.rev);
`endif
          last_mask = g.mask;
        end
      end
      PhyStatus = '0;
      RxStatus  = '0;
      start     = (cyc == 2);
      for (int i = 0; i < LANES; i++) begin
        if (rq[i] < 0 && TxDetectRx_Loopback[i]) rq[i] = cyc;
        if (rq[i] >= 0 && v.resp[i]) begin
          if (cyc == rq[i] + v.delay) begin
            detbit = (att <= 1) ? v.det1[i] : v.det2[i];
            PhyStatus[i] = 1'b1;
            RxStatus[3*i +: 3] = detbit ? 3'b011 : 3'b000;
            got[i] = 1'b1;
          end else if (got[i] && v.sticky) begin
            PhyStatus[i] = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; PhyStatus = '0; RxStatus = '0;
    chk("done_pulses", done_cnt, 1);
    if (sb.size() != 0) begin
      chk("done_missing", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    vec_t vt[11];
    //        dly resp      det1      det2      stk mask      cnt w   wlr rev to cyc   att
    vt[0]  = '{2, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 16'hFFFF, 16, 16, 16, 0, 0, 5,    1};
    vt[1]  = '{2, 16'hFFFF, 16'h00FF, 16'h0000, 0, 16'h00FF, 8,  8,  8,  0, 0, 5,    1};
    vt[2]  = '{2, 16'hFFF7, 16'hFFFF, 16'h0000, 1, 16'hFFF7, 15, 2,  8,  1, 1, 1027, 1};
    vt[3]  = '{2, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16, 16, 16, 0, 0, 265,  2};
    vt[4]  = '{2, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 0,  0,  0,  0, 0, 265,  2};
    vt[5]  = '{2, 16'hFFFF, 16'h0007, 16'h0000, 0, 16'h0007, 3,  2,  2,  0, 0, 5,    1};
    vt[6]  = '{1, 16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0001, 1,  1,  1,  0, 0, 4,    1};
    vt[7]  = '{5, 16'hFFFF, 16'h000F, 16'h0000, 0, 16'h000F, 4,  4,  4,  0, 0, 8,    1};
    vt[8]  = '{2, 16'hFFFF, 16'h7FFF, 16'h0000, 0, 16'h7FFF, 15, 8,  8,  0, 0, 5,    1};
    vt[9]  = '{2, 16'hFFFF, 16'hFFFE, 16'h0000, 0, 16'hFFFE, 15, 0,  8,  1, 0, 5,    1};
    vt[10] = '{2, 16'hFFFF, 16'hFF00, 16'h0000, 0, 16'hFF00, 8,  0,  8,  1, 0, 5,    1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; PhyStatus = '0; RxStatus = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    n_vec++;

    // start together with abort must not launch a sequence
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_req", TxDetectRx_Loopback, 0);
    n_vec++;

    for (int k = 0; k < 11; k++) run_vec(vt[k]);

    // abort in DETECT_WAIT
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("wait_req", TxDetectRx_Loopback, 16'hFFFF);
    chk("wait_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_req", TxDetectRx_Loopback, 0);
    chk("abort_busy", busy, 0);
    repeat (20) begin
      chk("abort_no_done", done, 0);
      @(posedge clk); #1;
    end
    chk("abort_mask_hold", detected_mask, last_mask);
    n_vec++;

    // asynchronous reset in DETECT_WAIT, between clock edges
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;

    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
